// File: rtl/sum3_mean_divider_if.sv
// Handshake bundle between the three-operand adder, the mean divider and its consumer.
// The slave modport is the divider's view; the master modport is the surrounding logic's view.
interface sum3_mean_divider_if #(
    parameter int OP_W = 4
);
    localparam int TW = OP_W + 2;

    logic [OP_W:0]   in_total_sum;
    logic            in_total_carry;
    logic            in_valid;
    logic            in_ready;
    logic [TW-1:0]   out_quotient;
    logic [1:0]      out_remainder;
    logic            out_over_range;
    logic            out_valid;
    logic            out_ready;

    modport slave (
        input  in_total_sum,
        input  in_total_carry,
        input  in_valid,
        output in_ready,
        output out_quotient,
        output out_remainder,
        output out_over_range,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_total_sum,
        output in_total_carry,
        output in_valid,
        input  in_ready,
        input  out_quotient,
        input  out_remainder,
        input  out_over_range,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sum3_mean_divider.sv
// Recovers the per-operand mean of a three-operand adder total: quotient and remainder of
// total/3 via a bit-serial restoring divider, plus a flag for totals no three operands can reach.
module sum3_mean_divider #(
    parameter int OP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sum3_mean_divider_if.slave      bus,
    output logic [1:0]              dbg_state
);
    localparam int TW = OP_W + 2;
    localparam int CW = $clog2(TW + 1);
    localparam logic [TW-1:0] MAX_SUM = TW'(3 * ((1 << OP_W) - 1));

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its data and valid until then, and ready never depends on valid.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  dividend_q, dividend_d;
    logic [2:0]     pr_q, pr_d;
    logic [TW-1:0]  quot_q, quot_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovr_q, ovr_d;
    logic [TW-1:0]  out_quotient_q, out_quotient_d;
    logic [1:0]     out_remainder_q, out_remainder_d;
    logic           out_over_range_q, out_over_range_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic [TW-1:0]  total;
    logic [2:0]     pr_shift;
    logic [2:0]     pr_step;
    logic           step_ge;

    assign total = {bus.in_total_carry, bus.in_total_sum};

    always_comb begin
        state_d          = state_q;
        dividend_d       = dividend_q;
        pr_d             = pr_q;
        quot_d           = quot_q;
        cnt_d            = cnt_q;
        ovr_d            = ovr_q;
        out_quotient_d   = out_quotient_q;
        out_remainder_d  = out_remainder_q;
        out_over_range_d = out_over_range_q;
        out_valid_d      = out_valid_q;

        // The partial remainder stays below 3, so the shifted value is at most 5 and fits in 3 bits.
        pr_shift = {pr_q[1:0], dividend_q[TW-1]};
        step_ge  = (pr_shift >= 3'd3);
        pr_step  = step_ge ? (pr_shift - 3'd3) : pr_shift;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = CALC;
                    dividend_d = total;
                    pr_d       = 3'd0;
                    quot_d     = '0;
                    cnt_d      = CW'(TW);
                    ovr_d      = (total > MAX_SUM);
                end
            end
            CALC: begin
                pr_d       = pr_step;
                quot_d     = {quot_q[TW-2:0], step_ge};
                dividend_d = dividend_q << 1;
                cnt_d      = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d          = DONE;
                    out_quotient_d   = {quot_q[TW-2:0], step_ge};
                    out_remainder_d  = pr_step[1:0];
                    out_over_range_d = ovr_q;
                    out_valid_d      = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            dividend_q       <= '0;
            pr_q             <= 3'd0;
            quot_q           <= '0;
            cnt_q            <= '0;
            ovr_q            <= 1'b0;
            out_quotient_q   <= '0;
            out_remainder_q  <= 2'd0;
            out_over_range_q <= 1'b0;
            out_valid_q      <= 1'b0;
            in_ready_q       <= 1'b1;
        end else begin
            state_q          <= state_d;
            dividend_q       <= dividend_d;
            pr_q             <= pr_d;
            quot_q           <= quot_d;
            cnt_q            <= cnt_d;
            ovr_q            <= ovr_d;
            out_quotient_q   <= out_quotient_d;
            out_remainder_q  <= out_remainder_d;
            out_over_range_q <= out_over_range_d;
            out_valid_q      <= out_valid_d;
            in_ready_q       <= in_ready_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_quotient   = out_quotient_q;
    assign bus.out_remainder  = out_remainder_q;
    assign bus.out_over_range = out_over_range_q;
    assign bus.out_valid      = out_valid_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_sum3_mean_divider.sv
// Bench for sum3_mean_divider: directed totals with literal expectations, plus an arithmetic
// model (t/3, t%3, t>45) checked against every presented result.
module tb_sum3_mean_divider;
  localparam int OP_W    = 4;
  localparam int TW      = OP_W + 2;
  localparam int MAX_SUM = 45;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  sum3_mean_divider_if #(.OP_W(OP_W)) bus ();

  sum3_mean_divider #(.OP_W(OP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int n_out = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: totals in acceptance order, with the edge each was accepted on
  logic [TW-1:0] exp_q[$];
  int            acc_q[$];
  bit            prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [TW-1:0] t;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({bus.in_total_carry, bus.in_total_sum});
        acc_q.push_back(cycle + 1);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          t = exp_q[0];
          check("mdl_quotient", int'(bus.out_quotient), int'(t) / 3);
          check("mdl_remainder", int'(bus.out_remainder), int'(t) % 3);
          check("mdl_over_range", int'(bus.out_over_range), int'(int'(t) > MAX_SUM));
          if (!prev_valid) check("mdl_latency", cycle - acc_q[0], TW);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            n_out++;
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  // drivers: entered and left at posedge+1
  task automatic drive_total(input logic [TW-1:0] t);
    bus.in_total_carry = t[TW-1];
    bus.in_total_sum   = t[TW-2:0];
  endtask

  task automatic send(input logic [TW-1:0] t, input bit bp);
    int guard = 0;
    bit acc = 1'b0;
    drive_total(t);
    bus.in_valid = 1'b1;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (bp) bus.out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    bus.in_valid = 1'b0;
    drive_total(~t);
    check("accept_timeout", int'(acc), 1);
  endtask

  task automatic wait_result();
    int guard = 0;
    bit got = 1'b0;
    while (!got && guard < 60) begin
      @(negedge clk);
      got = bus.out_valid;
      guard++;
    end
    check("result_timeout", int'(got), 1);
  endtask

  task automatic run_lit(input logic [TW-1:0] t, input int q, input int r, input int o);
    bus.out_ready = 1'b1;
    send(t, 1'b0);
    wait_result();
    check("lit_quotient", int'(bus.out_quotient), q);
    check("lit_remainder", int'(bus.out_remainder), r);
    check("lit_over_range", int'(bus.out_over_range), o);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive_total('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state, then idle with in_valid low
    @(negedge clk);
    check("rst_quotient", int'(bus.out_quotient), 0);
    check("rst_remainder", int'(bus.out_remainder), 0);
    check("rst_over_range", int'(bus.out_over_range), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_state", int'(dbg_state), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_in_ready", int'(bus.in_ready), 1);
      check("idle_out_valid", int'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;

    // directed totals; inputs are scrambled right after each accept
    run_lit(6'd45, 15, 0, 0);
    run_lit(6'd0, 0, 0, 0);
    run_lit(6'd44, 14, 2, 0);
    run_lit(6'd46, 15, 1, 1);
    run_lit(6'd63, 21, 0, 1);

    // backpressure in DONE with a pending total
    bus.out_ready = 1'b0;
    send(6'd45, 1'b0);
    wait_result();
    @(posedge clk);
    #1;
    drive_total(6'd30);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_quotient", int'(bus.out_quotient), 15);
      check("bp_remainder", int'(bus.out_remainder), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    check("bp_release_quotient", int'(bus.out_quotient), 15);
    @(negedge clk);
    check("bp_pending_accepted", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result();
    check("bp_pending_quotient", int'(bus.out_quotient), 10);
    check("bp_pending_remainder", int'(bus.out_remainder), 0);
    @(posedge clk);
    #1;

    // reset after three divide steps
    bus.out_ready = 1'b1;
    send(6'd45, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_state", int'(dbg_state), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_quotient", int'(bus.out_quotient), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_result", int'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    run_lit(6'd27, 9, 0, 0);

    // sweep every total under random backpressure
    base = n_out;
    for (int t = 0; t < 64; t++) send(TW'(t), 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("sweep_count", n_out - base, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sum3_mean_divider.md
Name: sum3_mean_divider

Overview:
- Sequential inverse of the three-operand 4-bit adder: takes the adder's {carry, sum} total and recovers the per-operand mean.
- Computes quotient and remainder of total / 3 using a bit-serial restoring divider.
- Sits downstream of the three-operand adder. Valid/ready handshake on both sides.
- Also flags totals that no three OP_W-bit operands can produce.

Parameters:
- OP_W, 4, operand width of the upstream adder.
- Derived TW = OP_W+2: dividend width and iteration count.
- Derived MAX_SUM = 3*(2^OP_W-1), which is 45 at the default.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_total_sum  input  OP_W+1  low bits of the total (adder sum output).
- in_total_carry  input  1  MSB of the total (adder carry output); total = {in_total_carry, in_total_sum}.
- in_valid  input  1  total is valid.
- in_ready  output  1  block can accept a total.
- out_quotient  output  TW  floor(total/3).
- out_remainder  output  2  total mod 3.
- out_over_range  output  1  total > MAX_SUM.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; quotient, remainder, over_range, out_valid, working registers and counter all 0.
- in_ready is 1 in IDLE only, and is registered from the state.
- States are IDLE, CALC and DONE.
- IDLE -> CALC on a clk edge with in_valid & in_ready. That edge does the following:
  - Captures the TW-bit total into the dividend shift register.
  - Clears the partial remainder (3 bits).
  - Loads the counter with TW.
  - Computes over_range = (total > MAX_SUM) and holds it internally.
- CALC, each edge, one restoring step:
  - pr' = {pr[1:0], dividend MSB}.
  - If pr' >= 3: pr = pr' - 3 and shift 1 into the quotient LSB; otherwise pr = pr' and shift 0.
  - Dividend shifts left by one; counter decrements.
- CALC -> DONE on the edge where the counter goes 1 -> 0. On that edge:
  - out_quotient, out_remainder and out_over_range are registered.
  - out_valid is set to 1.
- Latency: out_valid rises exactly TW clk edges after the accepting edge (6 at default).
- DONE behaviour:
  - Outputs and out_valid are held stable while out_ready = 0, for any number of cycles.
  - On an edge with out_ready = 1: go to IDLE and clear out_valid. Data outputs keep their last value.
- Throughput is one result per TW+2 cycles minimum; there is no overlap of accept and hand-off.
- Inputs are sampled only on the accepting edge; later changes to in_total_* do not affect the result.
- in_valid while not in IDLE is ignored (in_ready = 0); the upstream must hold it.
- out_ready outside DONE is ignored.
- Arithmetic:
  - Dividend range is 0..2^TW-1 (0..63). Quotient ≤ 21 at default.
  - Remainder is always 0..2; the value 3 never appears on out_remainder.
  - Over-range totals are still divided correctly; out_over_range is the only distinction.
- Reset mid-CALC or mid-DONE: immediate return to IDLE with out_valid = 0 and all registers cleared. The partial result is discarded and never presented.

Test Plan:
- Reset then release → all outputs 0, in_ready = 1, out_valid = 0. Hold in_valid = 0 for 5 cycles → state stays IDLE.
- carry=1, sum=5'b01101 (45) accepted → out_valid exactly 6 edges later with quotient=15, remainder=0, over_range=0. Also check 0 → 0 r0, and 44 → 14 r2.
- 46 → 15 r1, over_range=1; 63 → 21 r0, over_range=1. Change in_total_* during CALC → results unchanged.
- After 45 completes, hold out_ready=0 for 10 cycles with in_valid=1 and a new total → outputs stable, in_ready=0, nothing accepted. Raise out_ready → IDLE next edge, and the pending total is accepted the edge after.
- Assert rst_n low after 3 CALC iterations of 45 → out_valid stays 0 and state is IDLE immediately. After release, 27 → 9 r0 at 6-edge latency.
- Sweep all totals 0..63 with random out_ready backpressure → every result matches floor(t/3), t mod 3 and (t>45); no result is dropped or duplicated.
